// File: rtl/uart_tx_control_unit.sv
// Control FSM for the UART transmit path: sequences load/shift strobes and the
// serial output mux select through one start/data/stop frame per request.
module uart_tx_control_unit #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int CNT_WIDTH    = 8
) (
  input  logic       i_clock,
  input  logic       i_resetL,
  input  logic       i_tx_start,
  output logic       o_tx_busy,
  output logic       o_load,
  output logic       o_shift,
  output logic [1:0] o_tx_sel,
  output logic       o_tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           BIT_LAST  = 4'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic                 busy_q, busy_d;
  logic                 load_q, load_d;
  logic                 shift_q, shift_d;
  logic [1:0]           sel_q, sel_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (i_tx_start) state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else baud_d = baud_q + CNT_WIDTH'(1);
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 4'd1;
        end else baud_d = baud_q + CNT_WIDTH'(1);
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud_q + CNT_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up
  // with the state they describe, with no input-to-output combinational path.
  always_comb begin
    busy_d  = (state_d != IDLE);
    load_d  = (state_q == IDLE) && (state_d == START);
    shift_d = (state_d == DATA) && (baud_d == BAUD_LAST);
    done_d  = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   sel_d = 2'b01;
      DATA:    sel_d = 2'b10;
      STOP:    sel_d = 2'b11;
      default: sel_d = 2'b00;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      sel_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_busy = busy_q;
  assign o_load    = load_q;
  assign o_shift   = shift_q;
  assign o_tx_sel  = sel_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_control_unit.sv
// Bench for uart_tx_control_unit: default build plus a CLKS_PER_BIT=2/DATA_BITS=1
// build, both checked every cycle against a frame-position model.
module tb_uart_tx_control_unit;

  localparam int CA = 16, DA = 8, LA = (DA + 2) * CA;
  localparam int CB = 2,  DB = 1, LB = (DB + 2) * CB;

  logic clk = 1'b0;
  logic rst_n, start;
  logic       a_busy, a_load, a_shift, a_done;
  logic [1:0] a_sel;
  logic       b_busy, b_load, b_shift, b_done;
  logic [1:0] b_sel;

  int pass = 0, total = 0;

  always #5 clk = ~clk;

  uart_tx_control_unit dut_a (
    .i_clock(clk), .i_resetL(rst_n), .i_tx_start(start),
    .o_tx_busy(a_busy), .o_load(a_load), .o_shift(a_shift),
    .o_tx_sel(a_sel), .o_tx_done(a_done)
  );

  uart_tx_control_unit #(.CLKS_PER_BIT(CB), .DATA_BITS(DB), .CNT_WIDTH(8)) dut_b (
    .i_clock(clk), .i_resetL(rst_n), .i_tx_start(start),
    .o_tx_busy(b_busy), .o_load(b_load), .o_shift(b_shift),
    .o_tx_sel(b_sel), .o_tx_done(b_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: a frame is just a position t = 1..L inside the busy window.
  bit act_a, de_a, act_b, de_b;
  int t_a, t_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_a <= 1'b0; t_a <= 0; de_a <= 1'b0;
      act_b <= 1'b0; t_b <= 0; de_b <= 1'b0;
    end else begin
      de_a <= act_a && (t_a == LA);
      if (act_a) begin
        if (t_a == LA) act_a <= 1'b0;
        t_a <= t_a + 1;
      end else if (start) begin
        act_a <= 1'b1; t_a <= 1;
      end
      de_b <= act_b && (t_b == LB);
      if (act_b) begin
        if (t_b == LB) act_b <= 1'b0;
        t_b <= t_b + 1;
      end else if (start) begin
        act_b <= 1'b1; t_b <= 1;
      end
    end
  end

  // {busy, load, shift, sel, done} for frame position t
  function automatic logic [5:0] exp_out(input bit act, input int t, input bit de,
                                         input int c, input int d);
    logic [1:0] sel;
    logic ld, sh;
    sel = !act ? 2'd0 : (t <= c) ? 2'd1 : (t <= c * (d + 1)) ? 2'd2 : 2'd3;
    ld  = act && (t == 1);
    sh  = act && (t > c) && (t <= c * (d + 1)) && ((t % c) == 0);
    return {act, ld, sh, sel, de};
  endfunction

  always @(negedge clk) begin
    check("a_outputs", {26'd0, a_busy, a_load, a_shift, a_sel, a_done},
          {26'd0, exp_out(act_a, t_a, de_a, CA, DA)});
    check("b_outputs", {26'd0, b_busy, b_load, b_shift, b_sel, b_done},
          {26'd0, exp_out(act_b, t_b, de_b, CB, DB)});
  end

  int m_load, m_loadk, m_shift, m_fshift, m_busy, m_s1, m_s2, m_s3, m_first10;
  int m_dones, m_donek, mb_busy, mb_shift, mb_s2;

  // Observe n cycles; k=1 is the cycle right after the accepting edge.
  task automatic measure(input int n, input int rp);
    m_load = 0; m_loadk = 0; m_shift = 0; m_fshift = 0; m_busy = 0;
    m_s1 = 0; m_s2 = 0; m_s3 = 0; m_first10 = 0; m_dones = 0; m_donek = 0;
    mb_busy = 0; mb_shift = 0; mb_s2 = 0;
    for (int k = 1; k <= n; k++) begin
      if (a_load) begin m_load++; if (m_loadk == 0) m_loadk = k; end
      if (a_shift) begin m_shift++; if (m_fshift == 0) m_fshift = k; end
      if (a_busy) m_busy++;
      case (a_sel)
        2'd1: m_s1++;
        2'd2: begin m_s2++; if (m_first10 == 0) m_first10 = k; end
        2'd3: m_s3++;
        default: ;
      endcase
      if (a_done) begin m_dones++; m_donek = k; end
      if (b_busy) mb_busy++;
      if (b_shift) mb_shift++;
      if (b_sel == 2'd2) mb_s2++;
      start = (k == rp);
      @(posedge clk); #1;
    end
  endtask

  int dones, lows, loads;

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    // 1: start held through reset; frame begins on the first edge after release
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t1_load_after_reset", a_load, 1);

    // 2: single frame with default and minimal parameters
    measure(170, -1);
    check("t2_loads", m_load, 1);
    check("t2_load_cycle", m_loadk, 1);
    check("t2_busy_len", m_busy, 160);
    check("t2_sel01_len", m_s1, 16);
    check("t2_sel10_len", m_s2, 128);
    check("t2_sel11_len", m_s3, 16);
    check("t2_shifts", m_shift, 8);
    check("t2_first_shift_into_data", m_fshift - m_first10 + 1, 16);
    check("t2_dones", m_dones, 1);
    check("t2_done_cycle", m_donek, 161);
    check("t6_b_busy_len", mb_busy, 6);
    check("t6_b_shifts", mb_shift, 1);
    check("t6_b_sel10_len", mb_s2, 2);

    // 3: request re-pulsed in DATA is ignored
    start = 1'b1;
    @(posedge clk); #1;
    measure(170, 50);
    check("t3_loads", m_load, 1);
    check("t3_busy_len", m_busy, 160);
    check("t3_shifts", m_shift, 8);
    check("t3_done_cycle", m_donek, 161);

    // 4: start held -> back-to-back frames with one idle cycle between
    start = 1'b1;
    @(posedge clk); #1;
    dones = 0; lows = 0; loads = 0;
    for (int k = 1; k <= 3 * (LA + 1); k++) begin
      if (a_done) dones++;
      if (!a_busy) lows++;
      if (a_load) loads++;
      if (k == 3 * (LA + 1)) start = 1'b0;
      @(posedge clk); #1;
    end
    check("t4_dones", dones, 3);
    check("t4_idle_cycles", lows, 3);
    check("t4_loads", loads, 3);

    // 5: async reset in data bit 3 aborts the frame
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    check("t5_sel_before_reset", a_sel, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy_async", a_busy, 0);
    check("t5_sel_async", a_sel, 0);
    check("t5_strobes_async", {a_load, a_shift, a_done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    measure(5, -1);
    check("t5_no_done_after_abort", m_dones, 0);
    check("t5_idle_after_abort", m_busy, 0);
    start = 1'b1;
    @(posedge clk); #1;
    measure(170, -1);
    check("t5_loads", m_load, 1);
    check("t5_busy_len", m_busy, 160);
    check("t5_shifts", m_shift, 8);
    check("t5_done_cycle", m_donek, 161);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
